// File: rtl/mem_stage_sram_ctrl_if.sv
//==============================================================================
// Module  : mem_stage_sram_ctrl_if
// Brief   : Pipeline-side request/response and external SRAM signals of the
//           memory-stage SRAM controller.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_stage_sram_ctrl_if #(
   parameter int SRAM_ADDR_W = 18
);
   logic                   mem_r_en;
   logic                   mem_w_en;
   logic [31:0]            alu_res;
   logic [31:0]            val_rm;
   logic                   ready;
   logic [31:0]            rdata;
   logic [SRAM_ADDR_W-1:0] sram_addr;
   logic                   sram_we_n;
   logic [15:0]            sram_dq_out;
   logic                   sram_dq_oe;
   logic [15:0]            sram_dq_in;

   // Master is the pipeline plus SRAM device; slave is the controller.
   modport master (
      output mem_r_en, mem_w_en, alu_res, val_rm, sram_dq_in,
      input  ready, rdata, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
   );

   modport slave (
      input  mem_r_en, mem_w_en, alu_res, val_rm, sram_dq_in,
      output ready, rdata, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
   );
endinterface

`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
//==============================================================================
// Module  : mem_stage_sram_ctrl
// Brief   : Memory-stage controller splitting each 32-bit load/store into two
//           16-bit SRAM accesses; ready low freezes the pipeline meanwhile.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_stage_sram_ctrl #(
   parameter int          SRAM_ADDR_W = 18,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 2
) (
   input  wire logic            clk,
   input  wire logic            rst,
   mem_stage_sram_ctrl_if.slave bus
);

   localparam int               CNT_W  = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_op_wr;
   logic [SRAM_ADDR_W-2:0]  r_word;
   logic [31:0]             r_wdata;
   logic [31:0]             r_rdata;

   logic                    w_req;
   logic                    w_last;
   logic [31:0]             w_offset;
   logic [SRAM_ADDR_W-2:0]  w_word;

   logic                    w_ready;
   logic                    w_we_n;
   logic                    w_oe;
   logic [SRAM_ADDR_W-1:0]  w_addr;
   logic [15:0]             w_dq_out;

   assign w_req    = bus.mem_r_en | bus.mem_w_en;
   assign w_last   = (r_cnt == C_LAST);
   // Out-of-range addresses simply wrap; no error is raised.
   assign w_offset = bus.alu_res - BASE_ADDR;
   assign w_word   = (SRAM_ADDR_W-1)'(w_offset >> 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req)  w_next = S_LOW;
         S_LOW:   if (w_last) w_next = S_HIGH;
         S_HIGH:  if (w_last) w_next = S_DONE;
         // Request inputs still show the finished access here; ignore them.
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_op_wr <= 1'b0;
         r_word  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_op_wr <= bus.mem_w_en;
                  r_word  <= w_word;
                  r_wdata <= bus.val_rm;
                  r_cnt   <= '0;
               end
            end
            S_LOW, S_HIGH: begin
               if (w_last) begin
                  r_cnt <= '0;
                  if (!r_op_wr) begin
                     if (r_state == S_LOW) r_rdata[15:0]  <= bus.sram_dq_in;
                     else                  r_rdata[31:16] <= bus.sram_dq_in;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // SRAM-side outputs depend only on registered state and latched operands.
   always_comb begin
      w_ready  = 1'b0;
      w_we_n   = 1'b1;
      w_oe     = 1'b0;
      w_addr   = '0;
      w_dq_out = '0;
      case (r_state)
         S_IDLE: w_ready = ~w_req;
         S_LOW: begin
            w_addr = {r_word, 1'b0};
            if (r_op_wr) begin
               w_we_n   = 1'b0;
               w_oe     = 1'b1;
               w_dq_out = r_wdata[15:0];
            end
         end
         S_HIGH: begin
            w_addr = {r_word, 1'b1};
            if (r_op_wr) begin
               w_we_n   = 1'b0;
               w_oe     = 1'b1;
               w_dq_out = r_wdata[31:16];
            end
         end
         S_DONE:  w_ready = 1'b1;
         default: w_ready = 1'b1;
      endcase
   end

   assign bus.ready       = w_ready;
   assign bus.rdata       = r_rdata;
   assign bus.sram_addr   = w_addr;
   assign bus.sram_we_n   = w_we_n;
   assign bus.sram_dq_out = w_dq_out;
   assign bus.sram_dq_oe  = w_oe;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
//==============================================================================
// Module  : tb_mem_stage_sram_ctrl
// Brief   : Self-checking bench for mem_stage_sram_ctrl with an SRAM model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_stage_sram_ctrl;

   localparam int SRAM_ADDR_W = 18;
   localparam int WAIT_CYCLES = 2;

   typedef struct {
      logic        ready;
      logic        we_n;
      logic        oe;
      logic        chk_addr;
      logic [17:0] addr;
      logic        chk_dq;
      logic [15:0] dq;
      logic        chk_rd;
      logic [31:0] rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   logic [31:0] model_rdata;
   logic [15:0] sram_mem [0:63];

   mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(SRAM_ADDR_W)) bus ();

   mem_stage_sram_ctrl #(
      .SRAM_ADDR_W (SRAM_ADDR_W),
      .BASE_ADDR   (32'd1024),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!bus.sram_we_n) sram_mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
   end
   assign bus.sram_dq_in = sram_mem[bus.sram_addr[5:0]];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic push_cycle(input logic rdy, input logic wen, input logic oe,
                             input logic ca, input logic [17:0] a,
                             input logic cd, input logic [15:0] d,
                             input logic cr, input logic [31:0] rd);
      exp_t e;
      e.ready = rdy; e.we_n = wen; e.oe = oe;
      e.chk_addr = ca; e.addr = a;
      e.chk_dq = cd; e.dq = d;
      e.chk_rd = cr; e.rd = rd;
      sb_q.push_back(e);
   endtask

   // Drives one request at the start of a cycle and checks every cycle through DONE.
   // On return the request is still applied at the start of the following cycle.
   task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] load_val);
      logic [16:0] word;
      exp_t        e;
      word = 17'((a - 32'd1024) >> 2);
      if (!w) model_rdata = load_val;
      push_cycle(1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 1'b0, 16'd0, 1'b0, 32'd0);
      for (int i = 0; i < WAIT_CYCLES; i++)
         push_cycle(1'b0, ~w, w, 1'b1, {word, 1'b0}, w, d[15:0], 1'b0, 32'd0);
      for (int i = 0; i < WAIT_CYCLES; i++)
         push_cycle(1'b0, ~w, w, 1'b1, {word, 1'b1}, w, d[31:16], 1'b0, 32'd0);
      push_cycle(1'b1, 1'b1, 1'b0, 1'b0, 18'd0, 1'b0, 16'd0, 1'b1, model_rdata);

      bus.mem_r_en = r;
      bus.mem_w_en = w;
      bus.alu_res  = a;
      bus.val_rm   = d;
      for (int c = 0; c < 2 * WAIT_CYCLES + 2; c++) begin
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (bus.ready !== e.ready) begin
            errors++;
            $display("FAIL ready a=%0d cyc=%0d: got %b want %b", a, c, bus.ready, e.ready);
         end
         checks++;
         if (bus.sram_we_n !== e.we_n) begin
            errors++;
            $display("FAIL we_n a=%0d cyc=%0d: got %b want %b", a, c, bus.sram_we_n, e.we_n);
         end
         checks++;
         if (bus.sram_dq_oe !== e.oe) begin
            errors++;
            $display("FAIL dq_oe a=%0d cyc=%0d: got %b want %b", a, c, bus.sram_dq_oe, e.oe);
         end
         if (e.chk_addr) begin
            checks++;
            if (bus.sram_addr !== e.addr) begin
               errors++;
               $display("FAIL sram_addr a=%0d cyc=%0d: got %0d want %0d", a, c, bus.sram_addr, e.addr);
            end
         end
         if (e.chk_dq) begin
            checks++;
            if (bus.sram_dq_out !== e.dq) begin
               errors++;
               $display("FAIL dq_out a=%0d cyc=%0d: got %h want %h", a, c, bus.sram_dq_out, e.dq);
            end
         end
         if (e.chk_rd) begin
            checks++;
            if (bus.rdata !== e.rd) begin
               errors++;
               $display("FAIL rdata a=%0d cyc=%0d: got %h want %h", a, c, bus.rdata, e.rd);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_idle();
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_done: got ready=%b we_n=%b want 1 1", bus.ready, bus.sram_we_n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_mem(input int idx, input logic [15:0] want);
      checks++;
      if (sram_mem[idx] !== want) begin
         errors++;
         $display("FAIL sram_mem[%0d]: got %h want %h", idx, sram_mem[idx], want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
      bus.alu_res  = 32'd0;
      bus.val_rm   = 32'd0;
      model_rdata  = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe} !== 3'b110) begin
         errors++;
         $display("FAIL reset_ctrl: got ready/we_n/oe=%b want 110", {bus.ready, bus.sram_we_n, bus.sram_dq_oe});
      end
      checks++;
      if (bus.sram_addr !== 18'd0 || bus.sram_dq_out !== 16'd0 || bus.rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h dq=%h rdata=%h want 0", bus.sram_addr, bus.sram_dq_out, bus.rdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe} !== 3'b110) begin
            errors++;
            $display("FAIL idle cyc=%0d: got ready/we_n/oe=%b want 110", i, {bus.ready, bus.sram_we_n, bus.sram_dq_oe});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_store();
      run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'd0);
      set_idle();
      check_mem(2, 16'hBEEF);
      check_mem(3, 16'hDEAD);
   endtask

   task automatic test_load();
      run_access(1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF);
      set_idle();
   endtask

   task automatic test_both_asserted();
      run_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 32'd0);
      set_idle();
      check_mem(0, 16'h5678);
      check_mem(1, 16'h1234);
   endtask

   task automatic test_reset_abort();
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b1;
      bus.alu_res  = 32'd1040;
      bus.val_rm   = 32'h11112222;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.sram_we_n !== 1'b0 || bus.sram_addr !== 18'd9) begin
         errors++;
         $display("FAIL abort_pre: got we_n=%b addr=%0d want 0 9", bus.sram_we_n, bus.sram_addr);
      end
      rst = 1'b1;
      bus.mem_w_en = 1'b0;
      #1;
      checks++;
      if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe} !== 3'b110) begin
         errors++;
         $display("FAIL abort_ctrl: got ready/we_n/oe=%b want 110", {bus.ready, bus.sram_we_n, bus.sram_dq_oe});
      end
      checks++;
      if (bus.rdata !== 32'd0) begin
         errors++;
         $display("FAIL abort_rdata: got %h want 0", bus.rdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_rdata = 32'd0;
      run_access(1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF);
      set_idle();
   endtask

   task automatic test_back_to_back();
      run_access(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 32'd0);
      run_access(1'b0, 1'b1, 32'd1036, 32'h0BADC0DE, 32'd0);
      set_idle();
      run_access(1'b1, 1'b0, 32'd1032, 32'd0, 32'hCAFEF00D);
      run_access(1'b1, 1'b0, 32'd1036, 32'd0, 32'h0BADC0DE);
      set_idle();
      check_mem(6, 16'hC0DE);
      check_mem(7, 16'h0BAD);
   endtask

   initial begin
      test_reset();
      test_idle();
      test_store();
      test_load();
      test_both_asserted();
      test_reset_abort();
      test_back_to_back();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Memory-stage controller directly downstream of the EXE stage register. It consumes that register's MEM_r_en/MEM_w_en, ALU result (address) and Val_Rm (store data), and performs each 32-bit load/store as two 16-bit accesses on the external SRAM. It outputs `ready`; the pipeline uses its inverse as `freeze`, holding all upstream stages until the access completes.

Parameters:
- SRAM_ADDR_W, 18, SRAM half-word address width.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2, cycles spent on each 16-bit half access; legal range >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_r_en  in  1  load request, from EXE stage register.
- mem_w_en  in  1  store request, from EXE stage register.
- alu_res  in  32  CPU byte address.
- val_rm  in  32  store data.
- ready  out  1  1 = no access pending / access done; freeze = ~ready.
- rdata  out  32  load result.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_we_n  out  1  SRAM write enable, active-low.
- sram_dq_out  out  16  write data driven to SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus.
- sram_dq_in  in  16  read data from SRAM.

Behaviour:
- FSM states: IDLE, LOW, HIGH, DONE. Wait counter is clog2(WAIT_CYCLES)+1 bits wide.
- Reset values: state=IDLE, counter=0, rdata=0, latched addr/data/op=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0. ready=1.

IDLE:
- No request: ready=1 and state stays IDLE.
- Request (mem_r_en|mem_w_en): ready=0 combinationally in the same cycle.
- On that edge, latch:
  - op: write if mem_w_en, else read. Both asserted is treated as a write.
  - word = (alu_res - BASE_ADDR) >> 2, using 32-bit arithmetic that wraps modulo 2^32, then truncated to SRAM_ADDR_W-1 bits. No range error is flagged.
  - wdata = val_rm.
- Then counter=0 and state goes to LOW.

LOW:
- sram_addr={word,1'b0}.
- Write: sram_we_n=0, sram_dq_oe=1, sram_dq_out=wdata[15:0].
- Read: sram_we_n=1, sram_dq_oe=0.
- Counter increments each cycle. On the cycle where counter==WAIT_CYCLES-1:
  - read: rdata[15:0] <= sram_dq_in;
  - counter resets to 0 and state goes to HIGH.
- ready=0.

HIGH:
- Same as LOW, but with sram_addr={word,1'b1}, sram_dq_out=wdata[31:16], and a read captures rdata[31:16].
- On the last counter cycle, state goes to DONE.
- ready=0.

DONE:
- ready=1, sram_we_n=1, sram_dq_oe=0.
- Always goes to IDLE next, even if a request is still asserted on the inputs. The request inputs still show the completed instruction in this cycle and must not restart it.

Timing and other rules:
- Latency: the request is seen in cycle 0. ready is low in cycles 0..2*WAIT_CYCLES and high in cycle 2*WAIT_CYCLES+1 (DONE).
- Upstream holds its inputs stable while ready=0; the controller uses only latched values after IDLE.
- rdata holds its value until the next read overwrites it; writes do not change rdata.
- SRAM outputs are decoded from the registered state and latched values, with no combinational path from the request inputs. sram_we_n is never low in IDLE or DONE.
- Asynchronous rst during LOW/HIGH: immediately abort to IDLE with the reset values above. The partial SRAM write is not undone.
- Back-to-back: a new request arriving in the IDLE cycle right after DONE starts a new access. The minimum gap between accesses is one IDLE cycle.

Test Plan (WAIT_CYCLES=2, BASE_ADDR=1024):
1. Idle: mem_r_en=mem_w_en=0 for 10 cycles -> ready=1 and sram_we_n=1 throughout, sram_dq_oe=0.
2. Store 0xDEADBEEF to alu_res=1028 ->
   - cycles 1-2: sram_addr=2, sram_we_n=0, sram_dq_out=0xBEEF;
   - cycles 3-4: sram_addr=3, sram_dq_out=0xDEAD;
   - ready=0 in cycles 0-4 and 1 in cycle 5.
3. Load from 1028 with the SRAM model returning addr2=0xBEEF, addr3=0xDEAD -> rdata=0xDEADBEEF in cycle 5; sram_dq_oe=0 throughout.
4. mem_r_en=mem_w_en=1, alu_res=1024, val_rm=0x12345678 -> write to addrs 0 and 1 (0x5678, 0x1234); rdata unchanged.
5. Assert rst in cycle 3 of a store -> same cycle: sram_we_n=1, ready=1, state IDLE, rdata=0. A subsequent load completes normally.
6. Load from 1032 immediately followed by load from 1036 -> two independent 6-cycle accesses with exactly one IDLE cycle between DONE and the next LOW. DONE must not retrigger the first request.
